// File: rtl/sh_state_probe.sv
// sh_state_probe: captures a d-share masked state, recombines it (XOR of shares)
// and streams the unmasked bytes LANES per beat with optional compare.
// Debug/simulation use only: the output is unmasked by construction.
module sh_state_probe #(
    parameter int unsigned d     = 2,
    parameter int unsigned NB    = 16,
    parameter int unsigned LANES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*d*NB-1:0]       sh_in,
    input  logic [8*NB-1:0]         exp_in,
    input  logic                    cmp_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*LANES-1:0]      out_data,
    output logic [(((NB/LANES) > 1) ? $clog2(NB/LANES) : 1)-1:0] out_idx,
    output logic                    out_last,
    input  logic                    clr,
    output logic                    mismatch,
    output logic [15:0]             err_cnt
);

    localparam int unsigned BEATS = NB / LANES;
    localparam int unsigned IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SW    = 8 * d * NB;
    localparam int unsigned EW    = 8 * NB;
    localparam int unsigned OW    = 8 * LANES;
    localparam int unsigned SIW   = (SW > 1) ? $clog2(SW) : 1;
    localparam int unsigned EIW   = (EW > 1) ? $clog2(EW) : 1;
    localparam logic [IW-1:0] LAST_BEAT = IW'(BEATS - 1);

    // Reject parameter sets that cannot be streamed in whole beats
    if ((NB % LANES) != 0) begin : g_bad_lanes
        $error("sh_state_probe: NB must be a multiple of LANES");
    end
    if (d < 2) begin : g_bad_shares
        $error("sh_state_probe: d must be at least 2");
    end

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   beat_q;
    logic [IW-1:0]   beat_d;
    logic            capture;
    logic            xfer;
    logic            fail;
    logic [SW-1:0]   cap_sh;
    logic [EW-1:0]   cap_exp;
    logic            cap_cmp;
    logic [OW-1:0]   exp_beat;

    // State and beat registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next-state logic: accept a capture when idle, advance beats on transfer
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        capture = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    beat_d  = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    xfer = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture registers; frozen for the whole stream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_sh  <= '0;
            cap_exp <= '0;
            cap_cmp <= 1'b0;
        end else if (capture) begin
            cap_sh  <= sh_in;
            cap_exp <= exp_in;
            cap_cmp <= cmp_en;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == STREAM);
    assign out_idx   = beat_q;
    assign out_last  = (state_q == STREAM) && (beat_q == LAST_BEAT);

    // Recombine the current beat's bytes from the captured shares only
    always_comb begin
        int unsigned base;
        base     = 0;
        out_data = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            for (int unsigned b = 0; b < 8; b++) begin
                base = d * (8 * (32'(beat_q) * LANES + k) + b);
                out_data[8*k+b] = ^cap_sh[SIW'(base) +: d];
            end
        end
    end

    // Expected bytes for the current beat and the failing-transfer condition
    always_comb begin
        exp_beat = cap_exp[EIW'(32'(beat_q) * OW) +: OW];
        fail     = xfer && cap_cmp && (out_data != exp_beat);
    end

    // Sticky mismatch and saturating error count; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else if (clr) begin
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else if (fail) begin
            mismatch <= 1'b1;
            if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sh_state_probe.sv
// Self-checking bench for sh_state_probe: default configuration plus two
// parameter-sweep instances (d=3/LANES=1 and d=4/LANES=16).
module tb_sh_state_probe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Default instance (d=2, NB=16, LANES=4)
    logic         rst, in_valid, in_ready, cmp_en, out_valid, out_ready, out_last, clr, mismatch;
    logic [255:0] sh_in;
    logic [127:0] exp_in;
    logic [31:0]  out_data;
    logic [1:0]   out_idx;
    logic [15:0]  err_cnt;

    // Sweep instance A (d=3, LANES=1)
    logic         a_in_valid, a_in_ready, a_cmp_en, a_out_valid, a_out_ready, a_out_last, a_clr, a_mismatch;
    logic [383:0] a_sh;
    logic [127:0] a_exp;
    logic [7:0]   a_out_data;
    logic [3:0]   a_out_idx;
    logic [15:0]  a_err_cnt;

    // Sweep instance B (d=4, LANES=16)
    logic         b_in_valid, b_in_ready, b_cmp_en, b_out_valid, b_out_ready, b_out_last, b_clr, b_mismatch;
    logic [511:0] b_sh;
    logic [127:0] b_exp;
    logic [127:0] b_out_data;
    logic [0:0]   b_out_idx;
    logic [15:0]  b_err_cnt;

    sh_state_probe #(.d(2), .NB(16), .LANES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sh_in(sh_in),
        .exp_in(exp_in), .cmp_en(cmp_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .clr(clr),
        .mismatch(mismatch), .err_cnt(err_cnt)
    );

    sh_state_probe #(.d(3), .NB(16), .LANES(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .sh_in(a_sh),
        .exp_in(a_exp), .cmp_en(a_cmp_en), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_idx(a_out_idx), .out_last(a_out_last), .clr(a_clr),
        .mismatch(a_mismatch), .err_cnt(a_err_cnt)
    );

    sh_state_probe #(.d(4), .NB(16), .LANES(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .sh_in(b_sh),
        .exp_in(b_exp), .cmp_en(b_cmp_en), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_idx(b_out_idx), .out_last(b_out_last), .clr(b_clr),
        .mismatch(b_mismatch), .err_cnt(b_err_cnt)
    );

    // Reference model state
    int          err_m;
    bit          mis_m;
    int          err_a;
    bit          mis_a;
    logic [7:0]  p[16];
    logic [7:0]  e[16];
    logic [7:0]  q[16];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Random d-share encoding of the plain bytes pb (shares of a bit are contiguous)
    function automatic logic [511:0] mk_sh(input int dd, input logic [7:0] pb[16]);
        logic [511:0] v;
        logic [7:0]   acc;
        logic [7:0]   r;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            acc = pb[i];
            for (int s = 0; s < dd; s++) begin
                if (s == dd - 1) begin
                    r = acc;
                end else begin
                    r   = 8'($urandom);
                    acc = acc ^ r;
                end
                for (int b = 0; b < 8; b++) v[8*dd*i + dd*b + s] = r[b];
            end
        end
        return v;
    endfunction

    function automatic logic [127:0] pack16(input logic [7:0] pb[16]);
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) w[8*i +: 8] = pb[i];
        return w;
    endfunction

    function automatic logic [127:0] beat_word(input logic [7:0] pb[16], input int lanes, input int beat);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < lanes; k++) w[8*k +: 8] = pb[beat*lanes + k];
        return w;
    endfunction

    // One capture + stream on the default instance, checked every cycle
    task automatic run_main(input logic [7:0] pb[16], input logic [7:0] eb[16], input bit cmp,
                            input bit stall, input bit poke, input int clr_beat, input int abort_at,
                            input string tag);
        int           w;
        int           beat;
        int           cyc;
        bit           rdy;
        bit           f;
        logic [511:0] t;
        logic [7:0]   nb[16];
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk({tag, "_cap_timeout"}, 128'd0, 128'd1);
        t        = mk_sh(2, pb);
        sh_in    = t[255:0];
        exp_in   = pack16(eb);
        cmp_en   = cmp;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        sh_in    = {8{$urandom}};
        exp_in   = {4{$urandom}};
        cmp_en   = ~cmp;
        beat = 0;
        cyc  = 0;
        while (beat < 4 && cyc < 64) begin
            if (beat == abort_at) return;
            chk({tag, "_valid"}, 128'(out_valid), 128'd1);
            chk({tag, "_in_ready"}, 128'(in_ready), 128'd0);
            chk({tag, "_idx"}, 128'(out_idx), 128'(beat));
            chk({tag, "_last"}, 128'(out_last), 128'(beat == 3));
            chk({tag, "_data"}, 128'(out_data), beat_word(pb, 4, beat));
            chk({tag, "_mismatch"}, 128'(mismatch), 128'(mis_m));
            chk({tag, "_err_cnt"}, 128'(err_cnt), 128'(err_m));
            rdy       = stall ? ((cyc % 3) == 0) : 1'b1;
            out_ready = rdy;
            clr       = rdy && (beat == clr_beat);
            if (poke && cyc == 1) begin
                for (int i = 0; i < 16; i++) nb[i] = ~pb[i];
                t        = mk_sh(2, nb);
                sh_in    = t[255:0];
                in_valid = 1'b1;
            end
            @(posedge clk);
            if (rdy) begin
                f = 1'b0;
                for (int k = 0; k < 4; k++) if (pb[4*beat+k] != eb[4*beat+k]) f = cmp;
                if (clr) begin
                    mis_m = 1'b0;
                    err_m = 0;
                end else if (f) begin
                    mis_m = 1'b1;
                    if (err_m < 65535) err_m++;
                end
                beat++;
            end
            @(negedge clk);
            in_valid = 1'b0;
            clr      = 1'b0;
            cyc++;
        end
        if (cyc >= 64) chk({tag, "_stream_timeout"}, 128'd0, 128'd1);
        out_ready = 1'b1;
        chk({tag, "_end_in_ready"}, 128'(in_ready), 128'd1);
        chk({tag, "_end_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_end_mismatch"}, 128'(mismatch), 128'(mis_m));
        chk({tag, "_end_err_cnt"}, 128'(err_cnt), 128'(err_m));
    endtask

    // One capture + 16-beat stream on instance A; per-beat checks optional
    task automatic run_a(input logic [7:0] pb[16], input logic [7:0] eb[16], input bit cmp,
                         input bit check, input string tag);
        int           w;
        int           beat;
        int           cyc;
        logic [511:0] t;
        w = 0;
        while (a_in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk({tag, "_cap_timeout"}, 128'd0, 128'd1);
        t          = mk_sh(3, pb);
        a_sh       = t[383:0];
        a_exp      = pack16(eb);
        a_cmp_en   = cmp;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat < 16 && cyc < 40) begin
            if (check) begin
                chk({tag, "_valid"}, 128'(a_out_valid), 128'd1);
                chk({tag, "_idx"}, 128'(a_out_idx), 128'(beat));
                chk({tag, "_last"}, 128'(a_out_last), 128'(beat == 15));
                chk({tag, "_data"}, 128'(a_out_data), 128'(pb[beat]));
            end
            @(posedge clk);
            if (cmp && pb[beat] != eb[beat]) begin
                mis_a = 1'b1;
                if (err_a < 65535) err_a++;
            end
            @(negedge clk);
            beat++;
            cyc++;
        end
        if (cyc >= 40) chk({tag, "_stream_timeout"}, 128'd0, 128'd1);
        if (check) chk({tag, "_end_in_ready"}, 128'(a_in_ready), 128'd1);
    endtask

    // Single-beat capture on instance B
    task automatic run_b(input logic [7:0] pb[16], input string tag);
        b_sh       = mk_sh(4, pb);
        b_in_valid = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        chk({tag, "_valid"}, 128'(b_out_valid), 128'd1);
        chk({tag, "_in_ready"}, 128'(b_in_ready), 128'd0);
        chk({tag, "_idx"}, 128'(b_out_idx), 128'd0);
        chk({tag, "_last"}, 128'(b_out_last), 128'd1);
        chk({tag, "_data"}, b_out_data, pack16(pb));
        @(negedge clk);
        chk({tag, "_end_in_ready"}, 128'(b_in_ready), 128'd1);
        chk({tag, "_end_valid"}, 128'(b_out_valid), 128'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; cmp_en = 1'b0; out_ready = 1'b1; clr = 1'b0;
        sh_in = '0; exp_in = '0;
        a_in_valid = 1'b0; a_cmp_en = 1'b0; a_out_ready = 1'b1; a_clr = 1'b0;
        a_sh = '0; a_exp = '0;
        b_in_valid = 1'b0; b_cmp_en = 1'b0; b_out_ready = 1'b1; b_clr = 1'b0;
        b_sh = '0; b_exp = '0;
        err_m = 0; mis_m = 1'b0; err_a = 0; mis_a = 1'b0;
        for (int i = 0; i < 16; i++) p[i] = 8'(i);

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_data", 128'(out_data), 128'd0);
        chk("rst_idx", 128'(out_idx), 128'd0);
        chk("rst_last", 128'(out_last), 128'd0);
        chk("rst_mismatch", 128'(mismatch), 128'd0);
        chk("rst_err_cnt", 128'(err_cnt), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic recombine of P (byte i = i), no compare
        for (int i = 0; i < 16; i++) e[i] = p[i];
        run_main(p, e, 1'b0, 1'b0, 1'b0, -1, -1, "basic");

        // Backpressure with a mid-stream capture attempt
        run_main(p, e, 1'b0, 1'b1, 1'b1, -1, -1, "bp");

        // Compare fail on byte 5 (beat 1), twice, then a matching capture
        e[5] = 8'hFF;
        run_main(p, e, 1'b1, 1'b0, 1'b0, -1, -1, "cmp1");
        run_main(p, e, 1'b1, 1'b1, 1'b0, -1, -1, "cmp2");
        e[5] = p[5];
        run_main(p, e, 1'b1, 1'b0, 1'b0, -1, -1, "cmp_ok");

        // clr coincident with the failing beat-1 transfer
        e[5] = 8'hFF;
        run_main(p, e, 1'b1, 1'b0, 1'b0, 1, -1, "clr");

        // Asynchronous reset during beat 2 after a failing beat 1
        run_main(p, e, 1'b1, 1'b0, 1'b0, -1, 2, "pre_rst");
        chk("pre_rst_err", 128'(err_cnt), 128'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 128'(out_valid), 128'd0);
        chk("arst_in_ready", 128'(in_ready), 128'd1);
        chk("arst_data", 128'(out_data), 128'd0);
        chk("arst_idx", 128'(out_idx), 128'd0);
        chk("arst_last", 128'(out_last), 128'd0);
        chk("arst_mismatch", 128'(mismatch), 128'd0);
        chk("arst_err_cnt", 128'(err_cnt), 128'd0);
        err_m = 0;
        mis_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 128'(out_valid), 128'd0);
        for (int i = 0; i < 16; i++) begin
            q[i] = 8'($urandom);
            e[i] = q[i];
        end
        run_main(q, e, 1'b1, 1'b0, 1'b0, -1, -1, "post_rst");

        // Parameter sweep with random P
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 16; i++) q[i] = 8'($urandom);
            run_a(q, q, 1'b0, 1'b1, "sweep_a");
            run_b(q, "sweep_b");
        end
        chk("sweep_a_err", 128'(a_err_cnt), 128'd0);

        // Saturation on instance A: 4095 all-fail captures plus 14 failing bytes
        for (int i = 0; i < 16; i++) e[i] = ~q[i];
        for (int n = 0; n < 4095; n++) run_a(q, e, 1'b1, 1'b0, "sat_fill");
        e[14] = q[14];
        e[15] = q[15];
        run_a(q, e, 1'b1, 1'b0, "sat_fill");
        chk("sat_fffe", 128'(a_err_cnt), 128'(err_a));
        chk("sat_fffe_abs", 128'(a_err_cnt), 128'hFFFE);
        for (int i = 0; i < 16; i++) e[i] = q[i];
        e[0] = ~q[0];
        e[1] = ~q[1];
        run_a(q, e, 1'b1, 1'b1, "sat_top");
        chk("sat_ffff", 128'(a_err_cnt), 128'hFFFF);
        chk("sat_model", 128'(a_err_cnt), 128'(err_a));
        chk("sat_mismatch", 128'(a_mismatch), 128'(mis_a));
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        chk("sat_clr_err", 128'(a_err_cnt), 128'd0);
        chk("sat_clr_mismatch", 128'(a_mismatch), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sh_state_probe.md
# sh_state_probe

Sequential debug/verification probe that captures a d-share masked state of NB bytes and recombines it (XOR of all shares per bit). It streams the unmasked bytes out LANES bytes per beat over a valid/ready handshake, optionally comparing each beat against an expected value with sticky error reporting. It sits beside the masked AES datapath in simulation and FPGA debug builds only. It must never be instantiated in a secure production datapath, since its output is unmasked by construction.

## Interface
- d, 2, number of shares (≥2)
- NB, 16, number of state bytes
- LANES, 4, bytes recombined per output beat; NB % LANES == 0 (elaboration error otherwise)
- clk  in  1  clock, all state rising-edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  capture request
- in_ready  out  1  probe idle, capture accepted on in_valid & in_ready
- sh_in  in  8*d*NB  shared state; byte i at [8*d*i +: 8*d], bit b of byte i at [8*d*i + d*b +: d] (d shares contiguous)
- exp_in  in  8*NB  expected unmasked state, byte i at [8*i +: 8]
- cmp_en  in  1  compare enable, sampled with the capture
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_data  out  8*LANES  recombined bytes of current beat, byte k of beat at [8*k +: 8]
- out_idx  out  max(1,$clog2(NB/LANES))  beat index
- out_last  out  1  final beat of the capture
- clr  in  1  synchronous clear of mismatch and err_cnt
- mismatch  out  1  sticky compare-failure flag
- err_cnt  out  16  count of failing beats, saturating

## Operation
- FSM states: IDLE, STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid, register sh_in, exp_in and cmp_en, set beat=0, and go to STREAM.
- STREAM:
  - in_ready=0; in_valid is ignored and the captured data stays frozen.
  - out_valid=1 and out_idx=beat.
  - Byte k of out_data = XOR over shares of captured byte (beat*LANES+k).
  - out_last=(beat==NB/LANES-1).
- Beat transfer occurs on out_valid & out_ready:
  - If not last: beat+1, stay in STREAM.
  - If last: go to IDLE with beat=0.
  - If out_ready is low, out_data, out_idx and out_last hold stable.
- Compare: on each transfer with captured cmp_en=1, compare out_data against exp bytes [beat*LANES +: LANES]. On inequality:
  - mismatch is set.
  - err_cnt increments, saturating at 0xFFFF.
- clr:
  - Clears mismatch and err_cnt next edge.
  - If clr coincides with a failing transfer, clr wins and the result is 0 / 0.
  - clr does not affect the FSM or streaming.
- Recombination is purely from the captured register; no combinational path runs from sh_in to out_data.

## Timing
- Reset (async, any state, including mid-stream) gives:
  - IDLE, beat=0, captured registers 0.
  - in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0.
  - mismatch=0, err_cnt=0.
  - A partial stream is abandoned; no further beats follow.
- Capture accepted at edge t gives out_valid=1 from t (visible the cycle after acceptance), beat 0.
- With out_ready held high, the stream takes NB/LANES consecutive cycles. in_ready returns to 1 in the cycle after the last transfer. Minimum capture-to-capture period is NB/LANES+1 cycles.
- mismatch and err_cnt update at the edge of the failing transfer.
- NB/LANES==1: single beat, out_idx width 1 and always 0, out_last=1 throughout STREAM.

## Test plan
- **Basic recombine** (d=2, NB=16, LANES=4):
  - Stimulus: share0 = random R, share1 = R ^ P, with P byte i = i; out_ready=1, cmp_en=0.
  - Required response: beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; out_idx 0..3; out_last only on beat 3; in_ready=0 for exactly 4 cycles.
- **Backpressure**:
  - Stimulus: same capture, out_ready toggling 1,0,0,1,...; in_valid pulsed mid-stream with a different sh_in.
  - Required response: each beat held stable while stalled, no beat skipped or duplicated, and the mid-stream capture is ignored (still P).
- **Compare fail**:
  - Stimulus: cmp_en=1 with exp_in = P except byte 5 = 0xFF.
  - Required response: mismatch rises at the beat-1 transfer and err_cnt=1; a second identical capture gives err_cnt=2; a fully matching capture leaves both unchanged.
- **Clear/saturation**:
  - Stimulus 1: preload err_cnt to 0xFFFE via repeated failing captures, then two more failing beats.
    - Required response: err_cnt stays at 0xFFFF.
  - Stimulus 2: clr coincident with a failing transfer.
    - Required response: mismatch=0, err_cnt=0.
- **Reset mid-stream**:
  - Stimulus: assert rst asynchronously (between clock edges) during beat 2.
  - Required response: out_valid drops immediately, and all outputs take their reset values. After release, a new capture streams from beat 0.
- **Parameter sweep**:
  - Stimulus: d∈{2,3,4} with LANES∈{1,16}, random shares encoding random P.
  - Required response: the recombined stream equals P in byte order, with 16 beats (LANES=1) or 1 beat (LANES=16).
